// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one synchronous sprite/background ROM read port
// among NUM_REQ pixel-fetch requesters (0 grass/background, 1 duck, 2 dog).
// One ROM address is issued per cycle. A one-hot tag travels alongside each
// read so the returned word is steered back to its owner.
// Optional feature: define ROM_ARB_RR_EN for round-robin arbitration.
// The default build uses fixed priority, where the lowest index wins.
module sprite_rom_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = 17,
   parameter int DATA_W    = 8,
   parameter int ROM_DEPTH = 131072,
   parameter int ROM_LAT   = 2
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic [DATA_W-1:0]         rd_data,
   output logic [NUM_REQ-1:0]        rd_valid,
   output logic                      oob_err,
   output logic                      busy
);

   // The depth is widened by one bit so that ROM_DEPTH == 2**ADDR_W still
   // compares correctly against any address.
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(ROM_DEPTH);

   logic [NUM_REQ-1:0] gnt_raw;
   logic               win_any;
   logic [ADDR_W-1:0]  win_addr;
   logic               win_oob;

   // Stages 0..ROM_LAT-1 live in tag_q. The final stage is rd_valid_q itself.
   logic [NUM_REQ-1:0] tag_q [ROM_LAT];
   logic [NUM_REQ-1:0] tag_d [ROM_LAT];
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;
   logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
   logic               oob_q, oob_d;

`ifdef ROM_ARB_RR_EN
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] win_idx;

   // Round-robin search begins one past the last winner and wraps around.
   always_comb begin
      int cand;
      cand    = 0;
      gnt_raw = '0;
      win_idx = '0;
      win_any = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(ptr_q) + k) % NUM_REQ;
         if (!win_any && req[cand]) begin
            gnt_raw[cand] = 1'b1;
            win_idx       = IDX_W'(cand);
            win_any       = 1'b1;
         end
      end
      ptr_d = win_any ? win_idx : ptr_q;
   end

   // The pointer remembers the last granted requester.
   // On reset it points at the top index, so requester 0 is searched first.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         ptr_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: the lowest-indexed active request wins.
   always_comb begin
      gnt_raw = '0;
      win_any = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_any && req[i]) begin
            gnt_raw[i] = 1'b1;
            win_any    = 1'b1;
         end
      end
   end
`endif

   // Grants are suppressed while reset is held, so nothing issues during reset.
   always_comb begin
      gnt = Reset ? gnt_raw : '0;
   end

   // Select the winner's address and flag it if it lies beyond the ROM.
   always_comb begin
      win_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_raw[i]) begin
            win_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
      win_oob = ({1'b0, win_addr} >= DEPTH_W);
   end

   // Next-state logic covers the issue, the tag shift, data capture and the sticky error.
   always_comb begin
      rom_addr_d = rom_addr_q;
      oob_d      = oob_q;
      tag_d[0]   = gnt_raw;
      for (int s = 1; s < ROM_LAT; s++) begin
         tag_d[s] = tag_q[s-1];
      end
      rd_valid_d = tag_q[ROM_LAT-1];
      rd_data_d  = (|tag_q[ROM_LAT-1]) ? rom_data : rd_data_q;
      if (win_any) begin
         if (win_oob) begin
            rom_addr_d = '0;
            oob_d      = 1'b1;
         end else begin
            rom_addr_d = win_addr;
         end
      end
   end

   // State registers. Reset drops every read in flight.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         rom_addr_q <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= '0;
         oob_q      <= 1'b0;
         for (int s = 0; s < ROM_LAT; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         rom_addr_q <= rom_addr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         oob_q      <= oob_d;
         for (int s = 0; s < ROM_LAT; s++) begin
            tag_q[s] <= tag_d[s];
         end
      end
   end

   // Busy is high while any tag stage, including the final one, holds a read.
   always_comb begin
      busy = |rd_valid_q;
      for (int s = 0; s < ROM_LAT; s++) begin
         busy = busy | (|tag_q[s]);
      end
   end

   assign rom_addr = rom_addr_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign oob_err  = oob_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Testbench for sprite_rom_arbiter: a table of vectors plus hand-written
// multi-cycle sequences. A scoreboard queue tracks every expected ROM return.
module tb_sprite_rom_arbiter;

   localparam int NR    = 3;
   localparam int AW    = 17;
   localparam int DW    = 8;
   localparam int DEPTH = 76800;
   localparam int LAT   = 2;

   logic            Clk = 1'b0;
   logic            Reset;
   logic [NR-1:0]   req;
   logic [NR*AW-1:0] req_addr;
   logic [NR-1:0]   gnt;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_data;
   logic [DW-1:0]   rd_data;
   logic [NR-1:0]   rd_valid;
   logic            oob_err;
   logic            busy;

   typedef struct {
      logic [2:0] owner;
      logic [7:0] data;
      int         cycle;
   } exp_t;

   typedef struct {
      logic [2:0]  r;
      logic [16:0] a0;
      logic [16:0] a1;
      logic [16:0] a2;
      logic [2:0]  g_fixed;
      logic [2:0]  g_rr;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[11];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cycle_cnt    = 0;

   sprite_rom_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(DEPTH), .ROM_LAT(LAT)
   ) dut (
      .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .gnt(gnt),
      .rom_addr(rom_addr), .rom_data(rom_data), .rd_data(rd_data),
      .rd_valid(rd_valid), .oob_err(oob_err), .busy(busy)
   );

   always #10 Clk = ~Clk;

   always @(posedge Clk) cycle_cnt <= cycle_cnt + 1;

   // ROM contents are a simple hash of the address; word 0x100 holds 8'h5A.
   function automatic logic [7:0] rom_word(input logic [16:0] a);
      return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'h5B;
   endfunction

   // Out-of-range reads come back as word 0.
   function automatic logic [7:0] exp_word(input logic [16:0] a);
      logic [16:0] zero_addr;
      zero_addr = '0;
      return (int'(a) >= DEPTH) ? rom_word(zero_addr) : rom_word(a);
   endfunction

   // ROM macro model: rom_data follows rom_addr after one register stage.
   always @(posedge Clk) rom_data <= rom_word(rom_addr);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Every rd_valid pulse must match the oldest outstanding expectation.
   always @(negedge Clk) begin
      if (rd_valid !== 3'b000) begin
         tests_run++;
         if (sb_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL spurious_rd: rd_valid=%b rd_data=%h with nothing outstanding", rd_valid, rd_data);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (rd_valid !== e.owner || rd_data !== e.data || cycle_cnt != e.cycle) begin
               tests_failed++;
               $display("[TB] FAIL rd_return: got valid=%b data=%h cycle=%0d, expected valid=%b data=%h cycle=%0d",
                        rd_valid, rd_data, cycle_cnt, e.owner, e.data, e.cycle);
            end
         end
      end
   end

   // Drive one cycle of requests, check the grant, and record the expected return.
   task automatic applyStimulus(input logic [2:0] r, input logic [16:0] a0, input logic [16:0] a1,
                                input logic [16:0] a2, input logic [2:0] exp_gnt, input bit track);
      logic [16:0] sel;
      req      = r;
      req_addr = {a2, a1, a0};
      @(negedge Clk);
      checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
      sel = exp_gnt[0] ? a0 : (exp_gnt[1] ? a1 : a2);
      if (track && exp_gnt != 3'b000) begin
         sb_q.push_back('{exp_gnt, exp_word(sel), cycle_cnt + 3});
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic doReset(input int n);
      Reset = 1'b0;
      req   = '0;
      repeat (n) @(posedge Clk);
      #1;
      Reset = 1'b1;
   endtask

   task automatic idleCycles(input int n);
      req = '0;
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // Wait for all outstanding reads to return, with a bounded budget.
   task automatic drain();
      int waited;
      waited = 0;
      req    = '0;
      while (sb_q.size() != 0 && waited < 20) begin
         @(posedge Clk);
         waited++;
      end
      #1;
      checkOutput("drain_outstanding", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      logic [2:0] g;
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0] g;
      vecs[0]  = '{3'b001, 17'h00100, 17'h0,     17'h0,     3'b001, 3'b001};
      vecs[1]  = '{3'b000, 17'h0,     17'h0,     17'h0,     3'b000, 3'b000};
      vecs[2]  = '{3'b111, 17'h00020, 17'h00021, 17'h00022, 3'b001, 3'b010};
      vecs[3]  = '{3'b111, 17'h00020, 17'h00021, 17'h00022, 3'b001, 3'b100};
      vecs[4]  = '{3'b111, 17'h00020, 17'h00021, 17'h00022, 3'b001, 3'b001};
      vecs[5]  = '{3'b110, 17'h0,     17'h00030, 17'h00031, 3'b010, 3'b010};
      vecs[6]  = '{3'b100, 17'h0,     17'h0,     17'h00040, 3'b100, 3'b100};
      vecs[7]  = '{3'b101, 17'h00050, 17'h0,     17'h00051, 3'b001, 3'b001};
      vecs[8]  = '{3'b011, 17'h00060, 17'h00061, 17'h0,     3'b001, 3'b010};
      vecs[9]  = '{3'b000, 17'h0,     17'h0,     17'h0,     3'b000, 3'b000};
      vecs[10] = '{3'b010, 17'h0,     17'h12BFF, 17'h0,     3'b010, 3'b010};

      // Reset state, including a request held high during reset.
      Reset    = 1'b0;
      req      = '0;
      req_addr = '0;
      repeat (2) @(posedge Clk);
      #1;
      req = 3'b111;
      req_addr = {17'h00033, 17'h00022, 17'h00011};
      @(negedge Clk);
      checkOutput("gnt_in_reset", 32'(gnt), 32'd0);
      @(posedge Clk);
      #1;
      req   = '0;
      Reset = 1'b1;
      @(negedge Clk);
      checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
      checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
      checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("reset_oob_err", 32'(oob_err), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      @(posedge Clk);
      #1;

      // Single read with the latency and busy window.
      applyStimulus(3'b001, 17'h00100, 17'h0, 17'h0, 3'b001, 1'b1);
      req = '0;
      @(negedge Clk);
      checkOutput("single_rom_addr", 32'(rom_addr), 32'h100);
      checkOutput("single_busy_c1", 32'(busy), 32'd1);
      @(posedge Clk); #1;
      @(negedge Clk);
      checkOutput("single_busy_c2", 32'(busy), 32'd1);
      @(posedge Clk); #1;
      @(negedge Clk);
      checkOutput("single_busy_c3", 32'(busy), 32'd1);
      checkOutput("single_rd_data", 32'(rd_data), 32'h5A);
      @(posedge Clk); #1;
      @(negedge Clk);
      checkOutput("single_busy_c4", 32'(busy), 32'd0);
      checkOutput("rd_data_hold", 32'(rd_data), 32'h5A);
      @(posedge Clk); #1;
      drain();

      // Three-way contention straight after reset.
      doReset(1);
      for (int i = 0; i < 3; i++) begin
`ifdef ROM_ARB_RR_EN
         g = 3'(1 << i);
`else
         g = 3'b001;
`endif
         applyStimulus(3'b111, 17'h00020, 17'h00021, 17'h00022, g, 1'b1);
      end
      drain();

      // Back-to-back reads by requester 1 with no bubbles.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(3'b010, 17'h0, 17'(10 + i), 17'h0, 3'b010, 1'b1);
      end
      drain();

      // Vector table, ending with the last in-range address.
      doReset(1);
      for (int i = 0; i < 11; i++) begin
`ifdef ROM_ARB_RR_EN
         g = vecs[i].g_rr;
`else
         g = vecs[i].g_fixed;
`endif
         applyStimulus(vecs[i].r, vecs[i].a0, vecs[i].a1, vecs[i].a2, g, 1'b1);
      end
      drain();
      checkOutput("oob_clear_in_range", 32'(oob_err), 32'd0);

      // Out-of-range addresses, including the first address past the end.
      applyStimulus(3'b100, 17'h0, 17'h0, 17'h1FFFF, 3'b100, 1'b1);
      req = '0;
      @(negedge Clk);
      checkOutput("oob_rom_addr", 32'(rom_addr), 32'd0);
      checkOutput("oob_set", 32'(oob_err), 32'd1);
      @(posedge Clk); #1;
      applyStimulus(3'b010, 17'h0, 17'h12C00, 17'h0, 3'b010, 1'b1);
      req = '0;
      @(negedge Clk);
      checkOutput("oob_edge_rom_addr", 32'(rom_addr), 32'd0);
      @(posedge Clk); #1;
      drain();
      idleCycles(3);
      checkOutput("oob_sticky", 32'(oob_err), 32'd1);
      doReset(1);
      @(negedge Clk);
      checkOutput("oob_after_reset", 32'(oob_err), 32'd0);
      @(posedge Clk); #1;

      // Reset one cycle after a grant drops the read in flight.
      applyStimulus(3'b001, 17'h00077, 17'h0, 17'h0, 3'b001, 1'b0);
      Reset    = 1'b0;
      req      = 3'b001;
      req_addr = {17'h0, 17'h0, 17'h00078};
      @(negedge Clk);
      checkOutput("midflight_gnt_c1", 32'(gnt), 32'd0);
      @(posedge Clk); #1;
      @(negedge Clk);
      checkOutput("midflight_gnt_c2", 32'(gnt), 32'd0);
      checkOutput("midflight_busy", 32'(busy), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b1;
      idleCycles(5);
      checkOutput("midflight_rom_addr", 32'(rom_addr), 32'd0);
      checkOutput("midflight_busy_after", 32'(busy), 32'd0);

      // Requester 1 withdraws after one losing cycle and never gets a return.
      applyStimulus(3'b011, 17'h00005, 17'h00006, 17'h0, 3'b001, 1'b1);
      applyStimulus(3'b001, 17'h00007, 17'h0, 17'h0, 3'b001, 1'b1);
      drain();
      idleCycles(4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
